mula_sequencer: RTL and testbench
=================================

Name: mula_sequencer

Overview:
- Multi-cycle sequencer for the MULA (multiply-accumulate, FuncCode 6'b111000) operation of the pipelined MIPS datapath.
- Sits beside the single-cycle ALU in the EX stage. Decode/ALU control raises Start when ALUop==4'b1111 and FuncCode==MULA.
- Stalls the pipeline while an iterative radix-2 shift-add multiply runs, then adds the product into a 64-bit {Hi,Lo} accumulator.
- Unsigned arithmetic; the accumulator wraps modulo 2^(2*DATA_W).

Parameters:
DATA_W, 32, operand width; accumulator is 2*DATA_W, iteration count is DATA_W
CNT_W, 6, iteration counter width, must satisfy 2^CNT_W > DATA_W

Ports:
CLK  input  1  rising-edge clock
Reset_L  input  1  asynchronous active-low reset
Start  input  1  MULA request from EX; held high by the pipeline while stalled
Flush  input  1  squash in-flight MULA (branch/exception flush)
ClearAcc  input  1  zero the accumulator
BusA  input  DATA_W  multiplicand, sampled on accept
BusB  input  DATA_W  multiplier, sampled on accept
Stall  output  1  freeze PC/IF/ID/EX registers
Busy  output  1  state is RUN or ACCUM
Done  output  1  one-cycle pulse; accumulator updated
Hi  output  DATA_W  accumulator[2*DATA_W-1:DATA_W]
Lo  output  DATA_W  accumulator[DATA_W-1:0]

Behaviour:
- Reset (Reset_L low, asynchronous): state=IDLE, accumulator, partial, multiplicand, multiplier and count=0. Stall=0, Busy=0, Done=0, Hi=Lo=0. Reset mid-operation abandons the operation with no accumulator update.
- States: IDLE, RUN, ACCUM, DONE.
- IDLE:
  - Flush has priority; Start is not accepted in a Flush cycle.
  - ClearAcc=1 zeroes the accumulator at this edge.
  - Start=1 and Flush=0 accepts the request:
    - mcand <= zero-extended BusA (2*DATA_W bits); mplier <= BusB.
    - partial <= 0; count <= 0; next state RUN.
  - ClearAcc and Start in the same cycle: clear, then accept. The result is Acc = A*B.
- RUN, one iteration per cycle:
  - If mplier[0], partial <= partial + mcand.
  - mcand <= mcand<<1; mplier <= mplier>>1; count++.
  - After the DATA_W-th iteration (count==DATA_W-1 at the edge), next state is ACCUM.
  - Flush=1 in RUN: next state IDLE, accumulator unchanged, no Done.
- ACCUM: acc <= acc + partial, mod 2^(2*DATA_W). Next state DONE. Flush is ignored because the operation has committed.
- DONE: Done=1 and Stall=0, so the stalled MULA leaves EX at this edge. Start seen in DONE belongs to that same instruction and is ignored. Next state IDLE.
- ClearAcc is ignored in RUN, ACCUM and DONE.
- Stall (combinational) = (IDLE & Start & ~Flush) | RUN | ACCUM.
- Busy = RUN | ACCUM.
- Done is registered state decode. Hi/Lo come directly from the accumulator register.
- Latency: with Start accepted in cycle 0, RUN occupies cycles 1..DATA_W, ACCUM is cycle DATA_W+1 and Done is cycle DATA_W+2 (34 for DATA_W=32). Stall is high in cycles 0..DATA_W+1.
- Back-to-back MULA: the second request reaches EX in the cycle after DONE, which is IDLE, and is accepted there. The minimum spacing is therefore DATA_W+3 cycles.

Test Plan:
1. Assert Reset_L=0 mid-RUN -> Stall=Busy=Done=0 and Hi=Lo=0 immediately. After release, state is IDLE.
2. ClearAcc pulse, then Start with A=3, B=5 -> Stall high cycles 0..33, Done pulses only in cycle 34, Hi=0, Lo=15.
3. Following test 2, Start with A=0xFFFFFFFF, B=0xFFFFFFFF -> Done at cycle 34, Hi=0xFFFFFFFE, Lo=0x00000010.
4. With a nonzero accumulator, ClearAcc=1 and Start in the same IDLE cycle, A=2, B=7 -> Hi=0, Lo=14. ClearAcc pulsed during RUN has no effect.
5. Start with A=9, B=9, Flush=1 in cycle 10 -> Stall low from cycle 11, no Done, Hi/Lo unchanged. Flush asserted in the ACCUM cycle -> update still happens and Done pulses.
6. Start held high through DONE, then dropped -> exactly one accumulation and one Done. A new Start in the following IDLE cycle is accepted immediately, with Stall high that same cycle.

Source files
------------

// File: rtl/mula_sequencer_if.sv
// EX-stage connection between ALU control and the MULA sequencer.
// The master drives the request side; the slave returns stall, status and the accumulator.
interface mula_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              Start;
    logic              Flush;
    logic              ClearAcc;
    logic [DATA_W-1:0] BusA;
    logic [DATA_W-1:0] BusB;
    logic              Stall;
    logic              Busy;
    logic              Done;
    logic [DATA_W-1:0] Hi;
    logic [DATA_W-1:0] Lo;

    modport master (
        output Start, Flush, ClearAcc, BusA, BusB,
        input  Stall, Busy, Done, Hi, Lo
    );

    modport slave (
        input  Start, Flush, ClearAcc, BusA, BusB,
        output Stall, Busy, Done, Hi, Lo
    );
endinterface

// File: rtl/mula_sequencer.sv
// Multi-cycle MULA sequencer: radix-2 shift-add multiply, then {Hi,Lo} += product.
// The pipeline is stalled from the accept cycle until the cycle before Done.
module mula_sequencer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic           CLK,
    input  logic           Reset_L,
    mula_sequencer_if.slave bus
);
    localparam int ACC_W = 2 * DATA_W;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_partial;
    logic [ACC_W-1:0]   r_mcand;
    logic [DATA_W-1:0]  r_mplier;
    logic [CNT_W-1:0]   r_count;
    logic               w_accept;

    // Flush wins over Start in IDLE, so a squashed MULA never begins.
    assign w_accept = (r_state == S_IDLE) && bus.Start && !bus.Flush;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment first guarantees w_next_state is written on
    // every path, so no latch is inferred for unlisted cases.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.Flush) begin
                    w_next_state = S_IDLE;
                end else if (r_count == LAST_ITER) begin
                    w_next_state = S_ACCUM;
                end
            end
            S_ACCUM: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: these are plain registers, not a memory array, so they all take the
    // asynchronous reset; a reset mid-operation discards any in-flight product.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_acc     <= '0;
            r_partial <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_count   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.ClearAcc) begin
                        r_acc <= '0;
                    end
                    if (w_accept) begin
                        r_mcand   <= {{DATA_W{1'b0}}, bus.BusA};
                        r_mplier  <= bus.BusB;
                        r_partial <= '0;
                        r_count   <= '0;
                    end
                end
                S_RUN: begin
                    if (!bus.Flush) begin
                        if (r_mplier[0]) begin
                            r_partial <= r_partial + r_mcand;
                        end
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_count  <= r_count + 1'b1;
                    end
                end
                S_ACCUM: r_acc <= r_acc + r_partial;
                default: ;
            endcase
        end
    end

    assign bus.Stall = w_accept || (r_state == S_RUN) || (r_state == S_ACCUM);
    assign bus.Busy  = (r_state == S_RUN) || (r_state == S_ACCUM);
    assign bus.Done  = (r_state == S_DONE);
    assign bus.Hi    = r_acc[ACC_W-1:DATA_W];
    assign bus.Lo    = r_acc[DATA_W-1:0];
endmodule

// File: tb/tb_mula_sequencer.sv
// Bench for mula_sequencer: table of MULA operations with expected {Hi,Lo},
// plus hand sequences for reset, flush-in-IDLE and back-to-back issue.
module tb_mula_sequencer;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mula_sequencer_if #(.DATA_W(DW)) bus();

    mula_sequencer #(.DATA_W(DW), .CNT_W(6)) dut (
        .CLK     (clk),
        .Reset_L (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic          clear;      // ClearAcc in the accept cycle
        logic          clr_run;    // ClearAcc pulse in RUN (must be ignored)
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            flush_cyc;  // cycle number carrying Flush, 0 = none
        logic          b2b;        // issue right after the previous Done
        logic [DW-1:0] exp_hi;
        logic [DW-1:0] exp_lo;
    } vec_t;

    vec_t                vecs[12];
    logic [2*DW-1:0]     sb_q[$];
    int                  n_vec = 0;
    int                  n_err = 0;

    task automatic check(input string name, input logic [2*DW-1:0] act, input logic [2*DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic start, input logic flush, input logic clr,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.Start    = start;
        bus.Flush    = flush;
        bus.ClearAcc = clr;
        bus.BusA     = a;
        bus.BusB     = b;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b0, $urandom, $urandom);
            #1;
            check("idle_stall", 64'(bus.Stall), 64'd0);
            check("idle_busy", 64'(bus.Busy), 64'd0);
            check("idle_done", 64'(bus.Done), 64'd0);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [2*DW-1:0] got;
        logic [2*DW-1:0] exp;
        bit              flushed;
        int              last;
        flushed = (v.flush_cyc >= 1) && (v.flush_cyc <= DW);
        last    = flushed ? v.flush_cyc + 4 : DW + 2;

        // Cycle 0: request presented and accepted.
        @(negedge clk);
        drive(1'b1, 1'b0, v.clear, v.a, v.b);
        #1;
        if (!flushed) sb_q.push_back({v.exp_hi, v.exp_lo});
        check($sformatf("v%0d_c0_stall", idx), 64'(bus.Stall), 64'd1);
        check($sformatf("v%0d_c0_busy", idx), 64'(bus.Busy), 64'd0);
        check($sformatf("v%0d_c0_done", idx), 64'(bus.Done), 64'd0);

        for (int cyc = 1; cyc <= last; cyc++) begin
            @(negedge clk);
            // Operands change freely after accept; the pipeline holds Start while stalled and in DONE.
            drive(flushed ? (cyc <= v.flush_cyc) : 1'b1,
                  cyc == v.flush_cyc,
                  v.clr_run && (cyc == 5),
                  $urandom, $urandom);
            #1;
            check($sformatf("v%0d_c%0d_stall", idx, cyc), 64'(bus.Stall),
                  64'(flushed ? (cyc <= v.flush_cyc) : (cyc <= DW + 1)));
            check($sformatf("v%0d_c%0d_busy", idx, cyc), 64'(bus.Busy),
                  64'(flushed ? (cyc <= v.flush_cyc) : (cyc <= DW + 1)));
            check($sformatf("v%0d_c%0d_done", idx, cyc), 64'(bus.Done),
                  64'(!flushed && (cyc == DW + 2)));
            if (bus.Done === 1'b1) begin
                got = {bus.Hi, bus.Lo};
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL v%0d_unexpected_done: got Done=1 at cycle %0d, expected none", idx, cyc);
                end else begin
                    exp = sb_q.pop_front();
                    check($sformatf("v%0d_acc", idx), got, exp);
                end
            end
        end

        if (flushed) begin
            check($sformatf("v%0d_acc_unchanged", idx), {bus.Hi, bus.Lo}, {v.exp_hi, v.exp_lo});
        end
        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL v%0d_missing_done: got no Done within %0d cycles, expected one", idx, last);
            sb_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t pre;
        //            clear clr_run a             b             flush b2b  exp_hi        exp_lo
        vecs[0]  = '{1'b1, 1'b0, 32'd3,        32'd5,        0,  1'b0, 32'd0,        32'd15};
        vecs[1]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0,  1'b0, 32'hFFFFFFFE, 32'h00000010};
        vecs[2]  = '{1'b1, 1'b1, 32'd2,        32'd7,        0,  1'b0, 32'd0,        32'd14};
        vecs[3]  = '{1'b0, 1'b0, 32'd9,        32'd9,        10, 1'b0, 32'd0,        32'd14};
        vecs[4]  = '{1'b0, 1'b0, 32'd9,        32'd9,        33, 1'b0, 32'd0,        32'd95};
        vecs[5]  = '{1'b0, 1'b0, 32'd4,        32'd5,        0,  1'b0, 32'd0,        32'd115};
        vecs[6]  = '{1'b0, 1'b0, 32'd1,        32'd1,        0,  1'b1, 32'd0,        32'd116};
        vecs[7]  = '{1'b0, 1'b0, 32'h80000000, 32'd2,        0,  1'b1, 32'd1,        32'd116};
        vecs[8]  = '{1'b0, 1'b0, 32'd0,        32'hFFFFFFFF, 0,  1'b0, 32'd1,        32'd116};
        vecs[9]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'd1,        0,  1'b0, 32'd0,        32'hFFFFFFFF};
        vecs[10] = '{1'b0, 1'b0, 32'd5,        32'd5,        1,  1'b0, 32'd0,        32'hFFFFFFFF};
        vecs[11] = '{1'b0, 1'b0, 32'd5,        32'd5,        32, 1'b0, 32'd0,        32'hFFFFFFFF};

        drive(1'b0, 1'b0, 1'b0, '0, '0);
        #12 rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_stall", 64'(bus.Stall), 64'd0);
        check("rst_busy", 64'(bus.Busy), 64'd0);
        check("rst_done", 64'(bus.Done), 64'd0);
        check("rst_acc", {bus.Hi, bus.Lo}, 64'd0);

        // Load a nonzero accumulator, then reset in the middle of the next RUN.
        pre = '{1'b0, 1'b0, 32'd6, 32'd7, 0, 1'b0, 32'd0, 32'd42};
        run_vec(100, pre);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'd3, 32'd3);
        repeat (10) @(negedge clk);
        #1;
        check("mid_run_busy", 64'(bus.Busy), 64'd1);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        check("async_rst_stall", 64'(bus.Stall), 64'd0);
        check("async_rst_busy", 64'(bus.Busy), 64'd0);
        check("async_rst_done", 64'(bus.Done), 64'd0);
        check("async_rst_acc", {bus.Hi, bus.Lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(3);
        check("post_rst_acc", {bus.Hi, bus.Lo}, 64'd0);

        // Flush in the same IDLE cycle as Start: not accepted.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'd8, 32'd8);
        #1;
        check("idle_flush_stall", 64'(bus.Stall), 64'd0);
        idle_cycles(2);

        for (int i = 0; i < 12; i++) begin
            if (!vecs[i].b2b) idle_cycles(1);
            run_vec(i, vecs[i]);
        end
        idle_cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
